output_requant_buffer: RTL and testbench
========================================

OUTPUT_REQUANT_BUFFER -- requirements
Module: output_requant_buffer

Interface
REQ-001 Parameter ACCUMULATION_WIDTH, default 32, width of the incoming MAC accumulator value.
REQ-002 Parameter IO_DATA_WIDTH, default 16, width of the requantized output word.
REQ-003 Parameter FIFO_DEPTH, default 4, number of output entries buffered (power of two, >=2).
REQ-004 Parameter FEATURE_MAP_WIDTH, default 1024; FEATURE_MAP_HEIGHT, default 1024; OUTPUT_NB_CHANNELS, default 64, which size the coordinate ports.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 arst_n_in  input  1  reset, synchronous, active-low.
REQ-007 acc_in  input  ACCUMULATION_WIDTH  signed accumulator value from the MAC stage.
REQ-008 in_valid  input  1  acc_in and the coordinates are valid this cycle.
REQ-009 in_x / in_y / in_ch  input  clog2(FEATURE_MAP_WIDTH) / clog2(FEATURE_MAP_HEIGHT) / clog2(OUTPUT_NB_CHANNELS)  output pixel coordinates.
REQ-010 in_ready  output  1  buffer can accept an entry this cycle.
REQ-011 shift  input  5  right-shift amount for requantization (0..31), sampled on accept.
REQ-012 relu_en  input  1  clamp negative results to 0, sampled on accept.
REQ-013 out_data  output  IO_DATA_WIDTH  signed requantized value at the FIFO head.
REQ-014 out_x / out_y / out_ch  output  same widths as the in_ coordinates  coordinates of the head entry.
REQ-015 out_valid  output  1  head entry present.
REQ-016 out_ready  input  1  downstream consumes the head when out_valid is high.
REQ-017 fifo_count  output  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-018 drop_err  output  1  sticky flag: an input was offered while the buffer was full.
REQ-019 sat_count  output  16  number of accepted entries that saturated; saturates at 65535.

Function
REQ-020 Accept (push) occurs when in_valid && in_ready; in_ready = (fifo_count < FIFO_DEPTH); in_ready has no combinational dependence on out_ready.
REQ-021 Pop occurs when out_valid && out_ready; out_valid = (fifo_count != 0).
REQ-022 Requant on accept: sum = acc_in + (shift==0 ? 0 : 1<<(shift-1)), computed at ACCUMULATION_WIDTH+1 bits without overflow; r = sum >>> shift (arithmetic).
REQ-023 If relu_en && r<0, r = 0.
REQ-024 Saturate r to [-2^(IO_DATA_WIDTH-1), 2^(IO_DATA_WIDTH-1)-1]; when clamping is applied, sat_count increments by 1, saturating at 65535.
REQ-025 The stored entry = {saturated r, in_x, in_y, in_ch}, written at the tail pointer; tail advances mod FIFO_DEPTH.
REQ-026 Latency: an entry accepted in cycle N into an empty FIFO appears on out_* with out_valid=1 in cycle N+1; no combinational input-to-output path.
REQ-027 Push and pop in the same cycle: both pointers advance, fifo_count unchanged; legal only while not full (a full FIFO blocks push even if a pop occurs).
REQ-028 Entries are output in acceptance order; out_* holds stable while out_valid && !out_ready.
REQ-029 Pointers wrap from FIFO_DEPTH-1 to 0.
REQ-030 in_valid && !in_ready: the entry is discarded, no state changes except that drop_err is set to 1 and remains set until reset.
REQ-031 Pop with fifo_count==0 is impossible (out_valid=0); out_ready is ignored.

Reset
REQ-032 While arst_n_in==0 at a rising clk edge: pointers=0, fifo_count=0, out_valid=0, in_ready=1 after the edge, drop_err=0, sat_count=0, out_data/out_x/out_y/out_ch=0.
REQ-033 Reset mid-operation discards all buffered entries; no pop or push is performed in the reset cycle.

Verification
REQ-034 Reset, then acc_in=0x00000180, shift=8, relu_en=0, one push -> next cycle out_valid=1, out_data=2 (0x180+0x80=0x200, >>8); the coordinates echo the inputs.
REQ-035 acc_in=-300 (0xFFFFFED4), shift=0, relu_en=1 -> out_data=0; relu_en=0 -> out_data=-300; sat_count stays 0.
REQ-036 acc_in=0x7FFFFFFF, shift=4 -> out_data=32767, sat_count=1; acc_in=0x80000000, shift=0 -> out_data=-32768, sat_count=2.
REQ-037 out_ready=0, push 4 entries -> fifo_count=4, in_ready=0; 5th in_valid -> drop_err=1, fifo_count stays 4; then out_ready=1 -> 4 entries pop in order, one per cycle.
REQ-038 fifo_count=2, continuous push and pop for 10 cycles -> fifo_count stays 2, order preserved across pointer wrap.
REQ-039 fifo_count=3, assert arst_n_in=0 for one cycle -> fifo_count=0, out_valid=0, drop_err=0, sat_count=0 on the following cycle.

Source files
------------

// File: rtl/output_requant_buffer_if.sv
// Bus bundle for output_requant_buffer: accumulator input side, requantized FIFO output side
// and status. master = producer/consumer environment, slave = the buffer itself.
interface output_requant_buffer_if #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
);
  localparam int X_W   = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int Y_W   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int CH_W  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic signed [ACCUMULATION_WIDTH-1:0] acc_in;
  logic                                 in_valid;
  logic        [X_W-1:0]                in_x;
  logic        [Y_W-1:0]                in_y;
  logic        [CH_W-1:0]               in_ch;
  logic                                 in_ready;
  logic        [4:0]                    shift;
  logic                                 relu_en;

  logic signed [IO_DATA_WIDTH-1:0]      out_data;
  logic        [X_W-1:0]                out_x;
  logic        [Y_W-1:0]                out_y;
  logic        [CH_W-1:0]               out_ch;
  logic                                 out_valid;
  logic                                 out_ready;

  logic        [CNT_W-1:0]              fifo_count;
  logic                                 drop_err;
  logic        [15:0]                   sat_count;

  modport master (
    output acc_in, in_valid, in_x, in_y, in_ch, shift, relu_en, out_ready,
    input  in_ready, out_data, out_x, out_y, out_ch, out_valid,
           fifo_count, drop_err, sat_count
  );

  modport slave (
    input  acc_in, in_valid, in_x, in_y, in_ch, shift, relu_en, out_ready,
    output in_ready, out_data, out_x, out_y, out_ch, out_valid,
           fifo_count, drop_err, sat_count
  );
endinterface

// File: rtl/output_requant_buffer.sv
// Requantizes MAC accumulators (round, arithmetic shift, optional ReLU, saturate) and
// buffers the results with their pixel coordinates in a small FIFO.
module output_requant_buffer #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input logic                      clk,
  input logic                      arst_n_in,
  output_requant_buffer_if.slave   bus
);
  localparam int X_W   = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int Y_W   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int CH_W  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = ACCUMULATION_WIDTH + 1;

  // Output range expressed at sum width so comparisons stay signed and exact.
  localparam logic signed [SUM_W-1:0] OUT_MAX =
    {{(SUM_W-IO_DATA_WIDTH+1){1'b0}}, {(IO_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OUT_MIN =
    {{(SUM_W-IO_DATA_WIDTH+1){1'b1}}, {(IO_DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic signed [IO_DATA_WIDTH-1:0] data;
    logic        [X_W-1:0]           x;
    logic        [Y_W-1:0]           y;
    logic        [CH_W-1:0]          ch;
  } entry_t;

  // Requantization datapath
  logic signed [SUM_W-1:0] sum_ext;
  logic signed [SUM_W-1:0] round_add;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic signed [SUM_W-1:0] relu_val;
  logic signed [SUM_W-1:0] clamped;
  logic                    sat_hit;
  entry_t                  entry_d;

  // FIFO state
  entry_t                  mem_q [FIFO_DEPTH];
  entry_t                  head;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    drop_err_q, drop_err_d;
  logic [15:0]             sat_count_q, sat_count_d;
  logic                    in_ready;
  logic                    out_valid;
  logic                    push;
  logic                    pop;

  // NOTE: always_comb uses blocking '=' so each intermediate is visible to the next line
  // in the same evaluation; clocked state below uses '<=' so all flops update together.
  always_comb begin
    sum_ext   = {bus.acc_in[ACCUMULATION_WIDTH-1], bus.acc_in};
    round_add = (bus.shift == 5'd0) ? '0 : (SUM_W'(1) << (bus.shift - 5'd1));
    sum       = sum_ext + round_add;
    shifted   = sum >>> bus.shift;
    relu_val  = (bus.relu_en && shifted[SUM_W-1]) ? '0 : shifted;
    sat_hit   = 1'b0;
    if (relu_val > OUT_MAX) begin
      clamped = OUT_MAX;
      sat_hit = 1'b1;
    end else if (relu_val < OUT_MIN) begin
      clamped = OUT_MIN;
      sat_hit = 1'b1;
    end else begin
      clamped = relu_val;
    end
    entry_d.data = clamped[IO_DATA_WIDTH-1:0];
    entry_d.x    = bus.in_x;
    entry_d.y    = bus.in_y;
    entry_d.ch   = bus.in_ch;
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it
  // unassigned; that is what keeps the next-state logic free of inferred latches.
  always_comb begin
    in_ready    = (count_q < CNT_W'(FIFO_DEPTH));
    out_valid   = (count_q != '0);
    push        = bus.in_valid && in_ready;
    pop         = out_valid && bus.out_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_err_d  = drop_err_q;
    sat_count_d = sat_count_q;

    // Depth is a power of two, so the natural pointer overflow is the wrap to 0.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (bus.in_valid && !in_ready) drop_err_d = 1'b1;

    if (push && sat_hit && (sat_count_q != 16'hFFFF)) sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_err_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_err_q  <= drop_err_d;
      sat_count_q <= sat_count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by count_q and
  // the outputs are forced to zero while empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (arst_n_in && push) mem_q[wr_ptr_q] <= entry_d;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    bus.in_ready = in_ready;
    bus.out_valid = out_valid;
    bus.out_data = out_valid ? head.data : '0;
    bus.out_x    = out_valid ? head.x    : '0;
    bus.out_y    = out_valid ? head.y    : '0;
    bus.out_ch   = out_valid ? head.ch   : '0;
    bus.fifo_count = count_q;
    bus.drop_err   = drop_err_q;
    bus.sat_count  = sat_count_q;
  end

  a_count_bounded : assert property (@(posedge clk) disable iff (!arst_n_in)
    count_q <= CNT_W'(FIFO_DEPTH));

  a_ptr_consistent : assert property (@(posedge clk) disable iff (!arst_n_in)
    (wr_ptr_q - rd_ptr_q) == count_q[PTR_W-1:0]);

endmodule

// File: tb/tb_output_requant_buffer.sv
// Directed bench for output_requant_buffer: table of requantization vectors plus
// hand-written sequences for full/drop, wrap-around streaming and mid-run reset.
module tb_output_requant_buffer;
  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  output_requant_buffer_if #(
    .ACCUMULATION_WIDTH(32), .IO_DATA_WIDTH(16), .FIFO_DEPTH(4),
    .FEATURE_MAP_WIDTH(1024), .FEATURE_MAP_HEIGHT(1024), .OUTPUT_NB_CHANNELS(64)
  ) bus ();

  output_requant_buffer #(
    .ACCUMULATION_WIDTH(32), .IO_DATA_WIDTH(16), .FIFO_DEPTH(4),
    .FEATURE_MAP_WIDTH(1024), .FEATURE_MAP_HEIGHT(1024), .OUTPUT_NB_CHANNELS(64)
  ) dut (
    .clk      (clk),
    .arst_n_in(arst_n_in),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] acc;
    logic [4:0]  shift;
    logic        relu;
    int          exp_data;
    logic        sat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int   model_q [$];
  int   exp_sat;

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_n_in    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    arst_n_in = 1'b1;
  endtask

  task automatic drive(input logic [31:0] acc, input logic [4:0] sh, input logic relu,
                       input int idx);
    bus.acc_in  = acc;
    bus.shift   = sh;
    bus.relu_en = relu;
    bus.in_x    = 10'(idx * 37 + 5);
    bus.in_y    = 10'(1000 - idx);
    bus.in_ch   = 6'(idx * 3);
  endtask

  initial begin
    bus.acc_in = '0; bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_ch = '0;
    bus.shift = '0; bus.relu_en = 1'b0; bus.out_ready = 1'b0;

    vecs[0] = '{32'h0000_0180, 5'd8,  1'b0, 2,      1'b0};
    vecs[1] = '{32'hFFFF_FED4, 5'd0,  1'b1, 0,      1'b0};
    vecs[2] = '{32'hFFFF_FED4, 5'd0,  1'b0, -300,   1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 5'd4,  1'b0, 32767,  1'b1};
    vecs[4] = '{32'h8000_0000, 5'd0,  1'b0, -32768, 1'b1};
    vecs[5] = '{32'hFFFF_FE80, 5'd8,  1'b0, -1,     1'b0};
    vecs[6] = '{32'h0000_7FFF, 5'd0,  1'b0, 32767,  1'b0};
    vecs[7] = '{32'h0000_8000, 5'd0,  1'b0, 32767,  1'b1};
    vecs[8] = '{32'h7FFF_FFFF, 5'd31, 1'b0, 1,      1'b0};
    vecs[9] = '{32'hFFFF_FFFB, 5'd1,  1'b0, -2,     1'b0};

    // Reset state
    do_reset();
    check("rst fifo_count", bus.fifo_count, 0);
    check("rst out_valid",  bus.out_valid, 0);
    check("rst in_ready",   bus.in_ready, 1);
    check("rst drop_err",   bus.drop_err, 0);
    check("rst sat_count",  bus.sat_count, 0);
    check("rst out_data",   bus.out_data, 0);

    // Requantization table: one push each, visible next cycle, then popped
    exp_sat = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].acc, vecs[i].shift, vecs[i].relu, i);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      if (vecs[i].sat) exp_sat++;
      check($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d out_data", i),  bus.out_data, vecs[i].exp_data);
      check($sformatf("vec%0d out_x", i),     bus.out_x, (i * 37 + 5) % 1024);
      check($sformatf("vec%0d out_y", i),     bus.out_y, 1000 - i);
      check($sformatf("vec%0d out_ch", i),    bus.out_ch, (i * 3) % 64);
      check($sformatf("vec%0d sat_count", i), bus.sat_count, exp_sat);
      tick();
      check($sformatf("vec%0d drained", i), bus.out_valid, 0);
    end

    // Fill to full, offer one more, then drain in order
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'(100 + k), 5'd0, 1'b0, k);
      bus.in_valid = 1'b1;
      tick();
    end
    check("full fifo_count", bus.fifo_count, 4);
    check("full in_ready",   bus.in_ready, 0);
    check("full drop_err",   bus.drop_err, 0);
    drive(32'd999, 5'd0, 1'b0, 9);
    tick();
    bus.in_valid = 1'b0;
    check("drop drop_err",   bus.drop_err, 1);
    check("drop fifo_count", bus.fifo_count, 4);
    check("drop head",       bus.out_data, 100);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d data", k), bus.out_data, 100 + k);
      check($sformatf("drain%0d x", k),    bus.out_x, k * 37 + 5);
      tick();
    end
    check("drain empty",    bus.out_valid, 0);
    check("drain count",    bus.fifo_count, 0);
    check("drain drop_err", bus.drop_err, 1);

    // Simultaneous push/pop at occupancy 2 across pointer wrap
    bus.out_ready = 1'b0;
    model_q.delete();
    for (int k = 0; k < 2; k++) begin
      drive(32'(200 + k), 5'd0, 1'b0, k);
      bus.in_valid = 1'b1;
      tick();
      model_q.push_back(200 + k);
    end
    check("stream start count", bus.fifo_count, 2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(32'(202 + k), 5'd0, 1'b0, k);
      bus.in_valid = 1'b1;
      check($sformatf("stream%0d head", k), bus.out_data, model_q[0]);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(202 + k);
      check($sformatf("stream%0d count", k), bus.fifo_count, 2);
    end
    bus.in_valid = 1'b0;
    while (model_q.size() > 0) begin
      check("stream tail", bus.out_data, model_q[0]);
      tick();
      void'(model_q.pop_front());
    end
    check("stream empty", bus.out_valid, 0);

    // Reset in the middle of operation with sticky flags set
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive((k == 0) ? 32'h7FFF_FFFF : 32'(k), 5'd4, 1'b0, k);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pre-rst count",     bus.fifo_count, 3);
    check("pre-rst drop_err",  bus.drop_err, 1);
    check("pre-rst sat_count", bus.sat_count, 1);
    arst_n_in     = 1'b0;
    bus.out_ready = 1'b1;
    drive(32'd5, 5'd0, 1'b0, 1);
    bus.in_valid = 1'b1;
    tick();
    arst_n_in     = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("mid-rst count",     bus.fifo_count, 0);
    check("mid-rst out_valid", bus.out_valid, 0);
    check("mid-rst drop_err",  bus.drop_err, 0);
    check("mid-rst sat_count", bus.sat_count, 0);
    check("mid-rst in_ready",  bus.in_ready, 1);
    check("mid-rst out_data",  bus.out_data, 0);
    tick();
    check("post-rst count", bus.fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
